alu_seq: RTL
============

# alu_seq

Parametrised, registered integer ALU. It succeeds the fixed 32-bit clocked ALU and adds:
- add/subtract with status flags, shifts, signed and unsigned compare;
- an iterative multi-cycle multiply;
- valid/ready handshakes on both input and output.

It sits between the operand/decode stage and writeback, and accepts one operation at a time.

## Interface
- `WIDTH`, default 32: operand/result width; legal values ≥ 4, power of two.
- `clk`  in  1  sole clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block can accept operation this cycle
- `a`, `b`  in  WIDTH  operands
- `sel`  in  4  opcode
- `out_valid`  out  1  result/flags valid
- `out_ready`  in  1  consumer takes result this cycle
- `out`  out  WIDTH  result
- `flags`  out  4  {n, z, c, v}: bit3 negative, bit2 zero, bit1 carry, bit0 overflow

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 1011 NOR.
  - 0011 ADD, 0100 SUB (a−b).
  - 0101 SLT (signed a<b → 1 else 0), 0110 SLTU (unsigned).
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL (low WIDTH bits of unsigned product).
  - All other codes are reserved and produce result 0.
- Shift amount is `b[$clog2(WIDTH)-1:0]`; upper bits of `b` are ignored.
- Flag rules:
  - n = result MSB and z = (result==0), for every opcode.
  - ADD: c = carry-out; v = signed overflow.
  - SUB: computed as a+~b+1; c = carry-out (1 when a ≥ b unsigned); v = signed overflow.
  - All other opcodes, reserved codes included: c=0, v=0.
- FSM states:
  - IDLE: `in_ready` = (!`out_valid` || `out_ready`). Accept = `in_valid` && `in_ready`. Single-cycle op: result/flags registered, stay in IDLE. MUL: latch a, b, clear accumulator and counter → MUL.
  - MUL: one shift-add step per cycle, multiplier LSB first. After step WIDTH−1, load result/flags, set `out_valid` → IDLE. `in_ready`=0 throughout.
- Output register:
  - `out_valid` rises when a result is loaded.
  - It falls on `out_ready` unless a new result loads on the same edge.
  - `out`/`flags` are stable while `out_valid` && !`out_ready`.
- Reset values: `out`=0, `flags`=0, `out_valid`=0, state IDLE, counter 0.
  - `in_ready`=1 while in reset and after release.
- Reset mid-MUL aborts the operation; no result is produced.
- Operand changes while `in_valid`=0 or during MUL have no effect.

## Timing
- Single-cycle ops: result and `out_valid` appear after the accept edge (latency 1).
- Back-to-back single-cycle ops run at 1/cycle while `out_ready`=1.
- MUL: `out_valid` rises WIDTH edges after the accept edge. `in_ready` is low for exactly WIDTH cycles after accept.
- The next operation is accepted on the same edge that `out_ready` drains a result: full throughput, no bubble.
- `in_ready` is combinational from state, `out_valid` and `out_ready`; there is no path from `in_valid`.

## Structure
- Package `alu_pkg` holds:
  - opcode enum `alu_op_e` with the codes above;
  - flag index constants `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V`.
- Sub-module `alu_mul_iter` (WIDTH param): a start/busy/done shift-add multiplier holding accumulator, multiplicand, multiplier and step counter.
- The top level holds the combinational datapath, the FSM and the output register.

## Test plan
All scenarios use WIDTH=32.
- ADD a=0xFFFFFFFF, b=1 → `out`=0, flags n0 z1 c1 v0, `out_valid` one cycle after accept.
- SUB a=0x80000000, b=1 → `out`=0x7FFFFFFF, flags n0 z0 c1 v1; SLT a=0xFFFFFFFF, b=0 → 1; SLTU same operands → 0.
- SRA a=0x80000000, b=0x24 (shift 4) → 0xF8000000, n=1; SLL a=1, b=31 → 0x80000000.
- MUL a=0x00010003, b=0x00020005 → `out`=0x000B000F, `out_valid` 32 edges after accept, `in_ready`=0 for those 32 cycles, flags n0 z0 c0 v0.
- Backpressure: `out_ready`=0, issue AND then OR back-to-back. The second op is held (`in_ready`=0) and `out` stays at the AND result. Raise `out_ready`: OR is accepted on that edge, and its result appears the next cycle.
- Assert `rst_n`=0 mid-MUL (cycle 10) → `out_valid`=0, `out`=0 immediately. After release `in_ready`=1, a following ADD 2+3 gives 5, and no stale MUL result ever appears.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu_seq block.
//   alu_op_e    - 4-bit opcode encoding presented on alu_seq.sel
//   alu_state_e - sequencer states (single-cycle idle vs. iterative multiply)
//   FLAG_*      - bit positions inside the 4-bit {n, z, c, v} flags bus
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SLTU = 4'b0110,
        OP_SLL  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1001,
        OP_MUL  = 4'b1010,
        OP_NOR  = 4'b1011
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle,
// LSB first. Produces the low WIDTH bits of the unsigned product.
//   clk, rst_n : clock, async active-low reset (aborts any run in progress)
//   start      : latch a/b, clear accumulator and step counter, go busy
//   a, b       : multiplicand / multiplier
//   busy       : a multiply is in progress
//   done       : high during the final step (step WIDTH-1)
//   product    : result of the current step; the full product when done=1
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;

    // Exposing the post-step value lets the caller capture the result on the
    // same edge as the last step instead of one cycle later.
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign product  = acc_next;
    assign done     = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;   // wraps to 0 after the last step
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered integer ALU with valid/ready on both sides.
// Single-cycle ops register their result on the accept edge; MUL runs
// WIDTH cycles in alu_mul_iter while the input side is held off.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operation handshake (in_ready has no in_valid path)
//   a, b, sel           : operands and opcode (alu_op_e)
//   out_valid/out_ready : result handshake
//   out, flags          : result and {n, z, c, v}
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e       state, state_next;
    alu_op_e          op;
    logic             mul_start, mul_busy, mul_done, load_single;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v;
    logic [WIDTH:0]   add_full, sub_full;
    logic [SW-1:0]    shamt;

    assign op    = alu_op_e'(sel);
    assign shamt = b[SW-1:0];

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Combinational datapath for the single-cycle opcodes.
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_ADD: begin
                res   = add_full[WIDTH-1:0];
                res_c = add_full[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_full[WIDTH-1:0];
                res_c = sub_full[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res[0] = $signed(a) < $signed(b);
            OP_SLTU: res[0] = a < b;
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $unsigned($signed(a) >>> shamt);
            default: res = '0;   // MUL handled by the iterator; reserved -> 0
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        mul_start   = 1'b0;
        load_single = 1'b0;
        case (state)
            ST_IDLE: begin
                // A held result that is draining this edge frees the slot.
                in_ready = !out_valid || out_ready;
                if (in_valid && in_ready) begin
                    if (op == OP_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else if (load_single) begin
            out       <= res;
            flags     <= {res[WIDTH-1], res == '0, res_c, res_v};
            out_valid <= 1'b1;
        end else if (state == ST_MUL && mul_done) begin
            out       <= mul_prod;
            flags     <= {mul_prod[WIDTH-1], mul_prod == '0, 1'b0, 1'b0};
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
